// File: rtl/dec_scan_seq.sv
// dec_scan_seq: scan sequencer for a 4-to-16 decoder's select/enable inputs.
//
// On an accepted start the select index `a` steps 0..last_idx. Each index gets
// BLANK_CYC cycles with en low, then max(dwell,1) cycles with en high, so every
// decoded line pulses cleanly. The scan is either one-shot or continuous. All
// outputs come straight from flops, so en is glitch-free.
//
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   start     - pulse: begin a scan (ignored while busy or when stop is high)
//   stop      - pulse: abort a running scan
//   cont      - 1 = wrap continuously, 0 = one-shot; sampled on start
//   dwell     - en-high cycles per index (0 is treated as 1); sampled on start
//   last_idx  - final index of the scan; sampled on start
//   a         - decoder select
//   en        - decoder enable
//   busy      - high from start acceptance until the scan ends or is stopped
//   wrap_tick - 1-cycle pulse when a continuous scan wraps last_idx -> 0
//   done_tick - 1-cycle pulse when a one-shot scan completes
module dec_scan_seq #(
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         last_idx,
  output logic [3:0]         a,
  output logic               en,
  output logic               busy,
  output logic               wrap_tick,
  output logic               done_tick
);

  // One counter serves both the blanking gap and the dwell, so it must hold
  // whichever reload value is wider.
  localparam int unsigned BlankW = $clog2(BLANK_CYC + 1);
  localparam int unsigned CntW   = (DWELL_W > BlankW) ? DWELL_W : BlankW;
  localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDwell} state_e;

  state_e             state_q, state_d;
  logic [3:0]         a_q, a_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         last_q, last_d;
  logic [CntW-1:0]    dwell_load;

  // Dwell reload is max(dwell_q,1)-1: a zero dwell behaves as one cycle.
  always_comb begin
    dwell_load = '0;
    if (dwell_q != '0) begin
      dwell_load = CntW'(dwell_q) - CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    en_d    = en_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    dwell_d = dwell_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          cont_d  = cont;
          dwell_d = dwell;
          last_d  = last_idx;
          a_d     = 4'd0;
          en_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = BlankLoad;
          state_d = StBlank;
        end
      end

      StBlank: begin
        if (stop) begin
          state_d = StIdle;
          a_d     = 4'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d   = dwell_load;
          en_d    = 1'b1;
          state_d = StDwell;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StDwell: begin
        // stop takes priority over a completion landing on the same edge.
        if (stop) begin
          state_d = StIdle;
          a_d     = 4'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // a only moves together with en falling, never while en is high.
          if (a_q != last_q) begin
            a_d     = a_q + 4'd1;
            en_d    = 1'b0;
            cnt_d   = BlankLoad;
            state_d = StBlank;
          end else if (cont_q) begin
            a_d     = 4'd0;
            en_d    = 1'b0;
            wrap_d  = 1'b1;
            cnt_d   = BlankLoad;
            state_d = StBlank;
          end else begin
            a_d     = 4'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        a_d     = 4'd0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= 4'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      dwell_q <= '0;
      last_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
    end
  end

  assign a         = a_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign wrap_tick = wrap_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Testbench for dec_scan_seq. Expected outputs come from a cycle-indexed
// model: j cycles after the start edge the scan is in index (j / period) and
// en is high once the phase within that period has passed the blanking gap.
module tb_dec_scan_seq;

  localparam int unsigned DW = 16;
  localparam int          B  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cont = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [3:0]    last_idx = 4'd0;
  logic [3:0]    a;
  logic          en;
  logic          busy;
  logic          wrap_tick;
  logic          done_tick;
  logic [7:0]    obs;

  int n_checks = 0;
  int n_pass   = 0;

  dec_scan_seq #(
    .DWELL_W  (DW),
    .BLANK_CYC(B)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .cont     (cont),
    .dwell    (dwell),
    .last_idx (last_idx),
    .a        (a),
    .en       (en),
    .busy     (busy),
    .wrap_tick(wrap_tick),
    .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  assign obs = {a, en, busy, wrap_tick, done_tick};

  // Expected {a, en, busy, wrap_tick, done_tick} j cycles after the start edge.
  function automatic logic [7:0] exp_vec(int j, bit c, int d, int l);
    int deff, p, nidx, t, i;
    logic [3:0] ai;
    bit e, w;
    deff = (d == 0) ? 1 : d;
    p    = B + deff;
    nidx = l + 1;
    t    = nidx * p;
    if (!c && j >= t) return (j == t) ? 8'h01 : 8'h00;
    i  = (j / p) % nidx;
    ai = 4'(i);
    e  = (j % p) >= B;
    w  = c && (j > 0) && ((j % t) == 0);
    return {ai, e, 1'b1, w, 1'b0};
  endfunction

  function automatic int scan_len(int d, int l);
    return (l + 1) * (B + ((d == 0) ? 1 : d));
  endfunction

  // Leaves the bench 1 time unit after the start edge (model index j = 0).
  task automatic pulse_start(bit c, int d, int l);
    cont     = c;
    dwell    = DW'(d);
    last_idx = 4'(l);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs !== 8'h00) $display("FAIL reset_state got %h exp %h", obs, 8'h00);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    pulse_start(1'b0, 4, 3);
    for (int j = 0; j < 28; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b0, 4, 3))
        $display("FAIL oneshot j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b0, 4, 3));
      else n_pass++;
      dwell    = DW'($urandom_range(0, 9));
      last_idx = 4'($urandom_range(0, 15));
      cont     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_continuous();
    pulse_start(1'b1, 3, 1);
    for (int j = 0; j < 39; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b1, 3, 1))
        $display("FAIL continuous j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b1, 3, 1));
      else n_pass++;
      @(posedge clk);
      #1;
    end
    // Last dwell cycle before a wrap: stop must win and suppress the wrap tick.
    n_checks++;
    if (obs !== exp_vec(39, 1'b1, 3, 1))
      $display("FAIL cont_prestop got %h exp %h", obs, exp_vec(39, 1'b1, 3, 1));
    else n_pass++;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs !== 8'h00) $display("FAIL cont_stop k=%0d got %h exp %h", k, obs, 8'h00);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_dwell_zero();
    pulse_start(1'b0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b0, 0, 0))
        $display("FAIL dwell_zero j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b0, 0, 0));
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_last15();
    pulse_start(1'b0, 1, 15);
    for (int j = 0; j < 51; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b0, 1, 15))
        $display("FAIL last15 j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b0, 1, 15));
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    pulse_start(1'b0, 5, 2);
    for (int k = 0; k < 10; k++) begin
      if (en === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!found) $display("FAIL async_wait_en got %b exp %b", found, 1'b1);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 8'h00) $display("FAIL async_reset got %h exp %h", obs, 8'h00);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(1'b0, 2, 1);
    for (int j = 0; j < 11; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b0, 2, 1))
        $display("FAIL post_reset j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b0, 2, 1));
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_stop_same();
    cont     = 1'b0;
    dwell    = DW'(3);
    last_idx = 4'd2;
    start    = 1'b1;
    stop     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs !== 8'h00) $display("FAIL start_stop k=%0d got %h exp %h", k, obs, 8'h00);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_while_busy();
    pulse_start(1'b0, 2, 2);
    for (int j = 0; j < 15; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b0, 2, 2))
        $display("FAIL busy_start j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b0, 2, 2));
      else n_pass++;
      if (j == 5) begin
        start    = 1'b1;
        dwell    = DW'(7);
        last_idx = 4'd9;
        cont     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    pulse_start(1'b0, 7, 0);
    for (int j = 0; j < 12; j++) begin
      n_checks++;
      if (obs !== exp_vec(j, 1'b0, 7, 0))
        $display("FAIL new_dwell j=%0d got %h exp %h", j, obs, exp_vec(j, 1'b0, 7, 0));
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    bit c;
    int d, l, t, ncyc;
    for (int it = 0; it < 8; it++) begin
      c    = 1'($urandom_range(0, 1));
      d    = int'($urandom_range(0, 5));
      l    = int'($urandom_range(0, 15));
      t    = scan_len(d, l);
      ncyc = c ? (2 * t + int'($urandom_range(0, t - 1))) : (t + 2);
      pulse_start(c, d, l);
      for (int j = 0; j < ncyc; j++) begin
        n_checks++;
        if (obs !== exp_vec(j, c, d, l))
          $display("FAIL random it=%0d j=%0d got %h exp %h", it, j, obs, exp_vec(j, c, d, l));
        else n_pass++;
        // Scramble sampled inputs and poke start while the scan is still busy.
        cont     = 1'($urandom_range(0, 1));
        dwell    = DW'($urandom_range(0, 20));
        last_idx = 4'($urandom_range(0, 15));
        start    = (c || j < t) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      if (c) begin
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL random_stop it=%0d got %h exp %h", it, obs, 8'h00);
        else n_pass++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_oneshot();
    test_continuous();
    test_dwell_zero();
    test_last15();
    test_async_reset();
    test_start_stop_same();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
